// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - SIMON 32/64 key schedule constants, state encoding and z0 lookup
package simon_pkg;

   localparam int KS_WORD  = 16;
   localparam int KS_M     = 4;
   localparam int KS_CNT_W = 6;
   localparam logic [KS_WORD-1:0] C_CONST = 16'hFFFC;

   // z0 with bit 0 = first sequence bit (two copies of the period-31 pattern)
   localparam logic [61:0] Z0_SEQ =
      62'b0110011100001101010010001011111_0110011100001101010010001011111;

   typedef enum logic [1:0] {
      KS_IDLE   = 2'd0,
      KS_PRIME  = 2'd1,
      KS_EMIT_F = 2'd2,
      KS_EMIT_R = 2'd3
   } ks_state_e;

   function automatic logic z0_bit(input logic [KS_CNT_W-1:0] idx);
      return (idx < 6'd62) ? Z0_SEQ[idx] : 1'b0;
   endfunction

endpackage

// File: rtl/simon_ks_step.sv
// rtl/simon_ks_step.sv - combinational SIMON 32/64 key-schedule step, forward or inverse
// Window packing is {w3,w2,w1,w0}; forward yields k[i+4], inverse yields k[j-4].
module simon_ks_step
   import simon_pkg::*;
(
   input  logic                      dir_i,
   input  logic [KS_M*KS_WORD-1:0]   win_i,
   input  logic                      z_i,
   output logic [KS_WORD-1:0]        new_o
);

   logic [KS_WORD-1:0] w0, w1, w2, w3;
   logic [KS_WORD-1:0] rot_src, xor_src, base, t;

   always_comb begin
      w0 = win_i[15:0];
      w1 = win_i[31:16];
      w2 = win_i[47:32];
      w3 = win_i[63:48];
      // inverse reuses the forward relation solved for the oldest word
      if (dir_i) begin
         rot_src = w2;
         xor_src = w0;
         base    = w3;
      end else begin
         rot_src = w3;
         xor_src = w1;
         base    = w0;
      end
      t     = {rot_src[2:0], rot_src[15:3]} ^ xor_src;
      t     = t ^ {t[0], t[15:1]};
      new_o = base ^ t ^ {15'd0, z_i} ^ C_CONST;
   end

endmodule

// File: rtl/simon_key_sched.sv
// rtl/simon_key_sched.sv - SIMON 32/64 round-key streamer, encrypt or decrypt order
// Define SIMON_KS_REV_CACHE_EN to keep the end window so repeat decrypts skip priming.
module simon_key_sched
   import simon_pkg::*;
#(
   parameter int ROUNDS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic        mode_i,
   input  logic [63:0] key_i,
   output logic [15:0] rk_data_o,
   output logic [4:0]  rk_round_o,
   output logic        rk_valid_o,
   input  logic        rk_ready_i,
   output logic        rk_last_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [KS_CNT_W-1:0] LAST_RND  = KS_CNT_W'(ROUNDS - 1);
   localparam logic [KS_CNT_W-1:0] FILL_RND  = KS_CNT_W'(ROUNDS - 4);
   localparam logic [KS_CNT_W-1:0] PRIME_END = KS_CNT_W'(ROUNDS - 5);

   ks_state_e             state_q, state_d;
   logic [63:0]           win_q, win_d;
   logic [KS_CNT_W-1:0]   cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  step_dir, step_z;
   logic [KS_CNT_W-1:0]   z_idx;
   logic [15:0]           step_new;
   logic                  cache_hit;
   logic [63:0]           cache_win;

   simon_ks_step u_step (
      .dir_i (step_dir),
      .win_i (win_q),
      .z_i   (step_z),
      .new_o (step_new)
   );

   // z0 is indexed by the absolute round of the word being retired/created
   assign step_dir = (state_q == KS_EMIT_R);
   assign z_idx    = step_dir ? cnt_q - 6'd4 : cnt_q;
   assign step_z   = z0_bit(z_idx);

   assign rk_valid_o = (state_q == KS_EMIT_F) || (state_q == KS_EMIT_R);
   assign busy_o     = (state_q != KS_IDLE);
   assign done_o     = done_q;
   assign rk_round_o = rk_valid_o ? cnt_q[4:0] : 5'd0;
   assign rk_last_o  = ((state_q == KS_EMIT_F) && (cnt_q == LAST_RND)) ||
                       ((state_q == KS_EMIT_R) && (cnt_q == '0));

   always_comb begin
      rk_data_o = '0;
      case (state_q)
         KS_EMIT_F: rk_data_o = win_q[15:0];
         KS_EMIT_R: rk_data_o = win_q[63:48];
         default:   rk_data_o = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         KS_IDLE: begin
            if (start_i && !abort_i) begin
               win_d = key_i;
               cnt_d = '0;
               if (!mode_i) begin
                  state_d = KS_EMIT_F;
               end else if (cache_hit) begin
                  win_d   = cache_win;
                  cnt_d   = LAST_RND;
                  state_d = KS_EMIT_R;
               end else begin
                  state_d = KS_PRIME;
               end
            end
         end
         KS_PRIME: begin
            win_d = {step_new, win_q[63:16]};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == PRIME_END) begin
               cnt_d   = LAST_RND;
               state_d = KS_EMIT_R;
            end
         end
         KS_EMIT_F: begin
            if (rk_ready_i) begin
               win_d = {step_new, win_q[63:16]};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_RND) begin
                  state_d = KS_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         KS_EMIT_R: begin
            if (rk_ready_i) begin
               win_d = {win_q[47:0], (cnt_q < 6'd4) ? 16'h0000 : step_new};
               cnt_d = cnt_q - 6'd1;
               if (cnt_q == '0) begin
                  state_d = KS_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = KS_IDLE;
      endcase
      if (abort_i) begin
         state_d = KS_IDLE;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= KS_IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

`ifdef SIMON_KS_REV_CACHE_EN
   logic [63:0] key_q, tag_q, cwin_q;
   logic        cache_vld_q;
   logic        fill_prime, fill_emit;

   // the end window exists right after the last prime step, or mid-encrypt at round R-4
   assign fill_prime = (state_q == KS_PRIME) && (cnt_q == PRIME_END) && !abort_i;
   assign fill_emit  = (state_q == KS_EMIT_F) && (cnt_q == FILL_RND) && !abort_i;
   assign cache_hit  = cache_vld_q && (key_i == tag_q);
   assign cache_win  = cwin_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q       <= '0;
         tag_q       <= '0;
         cwin_q      <= '0;
         cache_vld_q <= 1'b0;
      end else begin
         if ((state_q == KS_IDLE) && start_i) begin
            key_q <= key_i;
         end
         if (fill_prime || fill_emit) begin
            cache_vld_q <= 1'b1;
            tag_q       <= key_q;
            cwin_q      <= fill_prime ? win_d : win_q;
         end
      end
   end
`else
   assign cache_hit = 1'b0;
   assign cache_win = '0;
`endif

endmodule
